// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streaming byte-message front-end for the SHA-256 core.
// Packs input beats into a 64-byte block buffer, applies the 0x80 marker,
// zero fill and the 64-bit big-endian bit length, then hands each block to
// the core as a lead cycle followed by 16 words, paced on core_busy.
// Optional feature macro: SHA_PAD_LENCHK_EN (sticky length-overflow flag).
// LEN_W must not exceed 64.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// upstream holds in_data/in_nbytes/in_last stable until that edge, and
// in_valid without in_ready has no effect.
module sha256_msg_padder #(
  parameter int IN_BYTES = 4,
  parameter int LEN_W    = 32,
  localparam int NB_W    = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_BYTES-1:0] in_data,
  input  logic [NB_W-1:0]       in_nbytes,
  input  logic                  in_last,
  input  logic                  core_busy,
  output logic [31:0]           data,
  output logic                  write_enable,
  output logic                  first_block,
  output logic                  last_block,
  output logic                  len_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_PAD  = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4
  } state_t;

  state_t           state_q;
  logic [7:0]       blk_q [64];
  logic [5:0]       bp_q;         // next free byte in the block
  logic [LEN_W-1:0] len_q;        // message length in bits
  logic [3:0]       pw_q;         // word being written during PAD
  logic [4:0]       cnt_q;        // SEND cycle index
  logic [1:0]       hold_q;       // cycles left to ignore core_busy
  logic             mark_done_q;  // 0x80 marker already placed for this message
  logic             len_blk_q;    // the block being padded carries the length
  logic             final_q;      // the block waiting to be sent is the last one
  logic             pad_pend_q;   // another padding pass follows this send
  logic             first_pend_q; // the next block sent is block 0 of a message

  logic             accept;
  logic [6:0]       bp_sum;
  logic [63:0]      len64;
  logic [31:0]      len_word;
  logic [31:0]      rd_word;

`ifdef SHA_PAD_LENCHK_EN
  logic [LEN_W:0]   len_sum;
  assign len_sum = {1'b0, len_q} + {{(LEN_W+1-NB_W-3){1'b0}}, in_nbytes, 3'b000};
`else
  logic [LEN_W-1:0] len_sum;
  assign len_sum = len_q + {{(LEN_W-NB_W-3){1'b0}}, in_nbytes, 3'b000};
  assign len_err = 1'b0;
`endif

  assign accept    = in_valid && in_ready;
  assign bp_sum    = {1'b0, bp_q} + {{(7-NB_W){1'b0}}, in_nbytes};
  assign len64     = 64'(len_q);
  assign len_word  = pw_q[0] ? len64[31:0] : len64[63:32];
  assign rd_word   = {blk_q[{cnt_q[3:0], 2'd0}], blk_q[{cnt_q[3:0], 2'd1}],
                      blk_q[{cnt_q[3:0], 2'd2}], blk_q[{cnt_q[3:0], 2'd3}]};
  assign dbg_state = state_q;

  // Block buffer: message bytes land at bp during fill, padding words during PAD.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < IN_BYTES; i++) begin
        if (i < int'(in_nbytes)) begin
          blk_q[bp_q + 6'(i)] <= in_data[8*(IN_BYTES-1-i) +: 8];
        end
      end
    end else if (state_q == S_PAD) begin
      for (int j = 0; j < 4; j++) begin
        if (len_blk_q && pw_q >= 4'd14) begin
          blk_q[{pw_q, 2'(j)}] <= len_word[8*(3-j) +: 8];
        end else if (!mark_done_q && {pw_q, 2'(j)} == bp_q) begin
          blk_q[{pw_q, 2'(j)}] <= 8'h80;
        end else if ({pw_q, 2'(j)} >= bp_q) begin
          blk_q[{pw_q, 2'(j)}] <= 8'h00;
        end
      end
    end
  end

  // Control FSM with registered handshake and core-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bp_q         <= '0;
      len_q        <= '0;
      pw_q         <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      mark_done_q  <= 1'b0;
      len_blk_q    <= 1'b0;
      final_q      <= 1'b0;
      pad_pend_q   <= 1'b0;
      first_pend_q <= 1'b1;
      in_ready     <= 1'b0;
      data         <= '0;
      write_enable <= 1'b0;
      first_block  <= 1'b0;
      last_block   <= 1'b0;
`ifdef SHA_PAD_LENCHK_EN
      len_err      <= 1'b0;
`endif
    end else begin
      if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
      case (state_q)
        S_IDLE, S_FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            bp_q  <= bp_sum[5:0];
            len_q <= len_sum[LEN_W-1:0];
`ifdef SHA_PAD_LENCHK_EN
            if (len_sum[LEN_W]) len_err <= 1'b1;
`endif
            if (bp_sum[6]) begin
              // Block is data-full; a final beat here means padding starts
              // in a fresh block after this one is sent.
              state_q    <= S_WAIT;
              in_ready   <= 1'b0;
              final_q    <= 1'b0;
              pad_pend_q <= in_last;
            end else if (in_last) begin
              state_q   <= S_PAD;
              in_ready  <= 1'b0;
              pw_q      <= bp_sum[5:2];
              len_blk_q <= (bp_sum <= 7'd55);
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_PAD: begin
          if (!mark_done_q && bp_q[5:2] == pw_q) mark_done_q <= 1'b1;
          pw_q <= pw_q + 4'd1;
          if (pw_q == 4'd15) begin
            state_q    <= S_WAIT;
            final_q    <= len_blk_q;
            pad_pend_q <= !len_blk_q;
          end
        end
        S_WAIT: begin
          if (hold_q == 2'd0 && !core_busy) begin
            state_q     <= S_SEND;
            cnt_q       <= '0;
            first_block <= first_pend_q;
          end
        end
        S_SEND: begin
          if (cnt_q != 5'd16) begin
            write_enable <= 1'b1;
            data         <= rd_word;
            first_block  <= first_pend_q && (cnt_q == 5'd0);
            last_block   <= final_q && (cnt_q == 5'd0);
            cnt_q        <= cnt_q + 5'd1;
          end else begin
            write_enable <= 1'b0;
            data         <= '0;
            first_block  <= 1'b0;
            last_block   <= 1'b0;
            hold_q       <= 2'd2;
            first_pend_q <= 1'b0;
            bp_q         <= '0;
            pw_q         <= '0;
            if (final_q) begin
              state_q      <= S_IDLE;
              len_q        <= '0;
              mark_done_q  <= 1'b0;
              pad_pend_q   <= 1'b0;
              first_pend_q <= 1'b1;
              in_ready     <= 1'b1;
            end else if (pad_pend_q) begin
              // Either the length-only block or the marker block after a
              // message that ended on a block boundary.
              state_q    <= S_PAD;
              len_blk_q  <= 1'b1;
              pad_pend_q <= 1'b0;
            end else begin
              state_q  <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: three instances (IN_BYTES 4, 1, 2) share the
// clock, reset and core_busy. A reference padding model pushes every
// expected word to exp_q; a negedge monitor pops and compares.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        core_busy;
  logic [2:0]  in_valid;
  logic [2:0]  in_last;
  logic [2:0]  in_ready;
  logic [2:0]  we_o;
  logic [2:0]  fb_o;
  logic [2:0]  lb_o;
  logic [2:0]  le_o;
  logic [31:0] in_data   [3];
  logic [2:0]  in_nbytes [3];
  logic [31:0] data_o    [3];
  logic [2:0]  st_o      [3];

  logic [33:0] exp_q[$];
  logic [7:0]  msg_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          wcnt      [3];
  logic        prev_fb   [3];
  logic        prev_we   [3];
  logic [31:0] prev_data [3];
  int          lens [8] = '{1, 55, 60, 63, 64, 119, 128, 0};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int IB  = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
    localparam int NBW = $clog2(IB + 1);
    sha256_msg_padder #(.IN_BYTES(IB), .LEN_W(32)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid[g]),
      .in_ready     (in_ready[g]),
      .in_data      (in_data[g][8*IB-1:0]),
      .in_nbytes    (in_nbytes[g][NBW-1:0]),
      .in_last      (in_last[g]),
      .core_busy    (core_busy),
      .data         (data_o[g]),
      .write_enable (we_o[g]),
      .first_block  (fb_o[g]),
      .last_block   (lb_o[g]),
      .len_err      (le_o[g]),
      .dbg_state    (st_o[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ib_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 2);
  endfunction

  // Reference FIPS 180-4 padding of msg_q; one queue entry per word.
  task automatic push_expected();
    logic [7:0]  p[$];
    longint      bits;
    int          nblk;
    logic [31:0] w;
    p    = msg_q;
    bits = longint'(msg_q.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 16; k++) begin
        w = {p[64*b+4*k], p[64*b+4*k+1], p[64*b+4*k+2], p[64*b+4*k+3]};
        exp_q.push_back({(b == 0 && k == 0), (b == nblk - 1 && k == 0), w});
      end
    end
  endtask

  // Drive msg_q into instance d as left-justified beats, junk in unused lanes.
  task automatic send_msg(input int d);
    int          ib, idx, n, rem, to;
    logic        last;
    logic [31:0] w;
    push_expected();
    ib  = ib_of(d);
    idx = 0;
    @(negedge clk);
    while (1) begin
      rem = msg_q.size() - idx;
      if (rem <= ib) begin n = rem; last = 1'b1; end
      else begin n = ib; last = 1'b0; end
      w = $urandom;
      for (int i = 0; i < ib; i++) if (i < n) w[8*(ib-1-i) +: 8] = msg_q[idx+i];
      in_data[d]   = w;
      in_nbytes[d] = 3'(n);
      in_last[d]   = last;
      in_valid[d]  = 1'b1;
      to = 0;
      while (!in_ready[d] && to < 400) begin
        @(negedge clk);
        to++;
      end
      if (to >= 400) begin
        chk("ready_timeout", 1, 0);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
        return;
      end
      @(negedge clk);
      idx += n;
      if (last) break;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic fill_random(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_word(input int d);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_write", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    if (wcnt[d] % 16 == 0) begin
      chk("lead_first_block", prev_fb[d], e[33]);
      chk("lead_write_enable", prev_we[d], 0);
      chk("lead_data", prev_data[d], 0);
    end
    chk("data", data_o[d], e[31:0]);
    chk("first_block", fb_o[d], e[33]);
    chk("last_block", lb_o[d], e[32]);
  endtask

  // Scoreboard monitor: outputs sampled on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        wcnt[d] <= 0;
      end else if (we_o[d]) begin
        check_word(d);
        wcnt[d] <= wcnt[d] + 1;
      end
      prev_fb[d]   <= fb_o[d];
      prev_we[d]   <= we_o[d];
      prev_data[d] <= data_o[d];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol;
    reset     = 1'b0;
    core_busy = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    for (int d = 0; d < 3; d++) begin
      in_data[d]   = '0;
      in_nbytes[d] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", in_ready[d], 0);
      chk("rst_write_enable", we_o[d], 0);
      chk("rst_data", data_o[d], 0);
      chk("rst_first_block", fb_o[d], 0);
      chk("rst_last_block", lb_o[d], 0);
      chk("rst_len_err", le_o[d], 0);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("ready_after_reset", in_ready[d], 1);

    // 56 bytes of 0x30: marker at byte 56 forces a length-only block
    msg_q.delete();
    for (int i = 0; i < 56; i++) msg_q.push_back(8'h30);
    send_msg(0);
    wait_drain();

    // "abc" on the byte-wide instance
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    send_msg(1);
    wait_drain();

    // Empty message
    msg_q.delete();
    send_msg(0);
    wait_drain();

    // 64-byte message on the 2-byte instance: marker opens a second block
    fill_random(64);
    send_msg(2);
    wait_drain();

    // Boundary lengths spread over all three widths
    for (int k = 0; k < 8; k++) begin
      fill_random((k == 7) ? $urandom_range(0, 200) : lens[k]);
      send_msg(k % 3);
      wait_drain();
    end

    // Core busy holds a full block; SEND lead follows busy release by one cycle
    core_busy = 1'b1;
    fill_random(80);
    fork
      send_msg(0);
      begin
        repeat (40) @(negedge clk);
        viol = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (we_o[0] || in_ready[0]) viol++;
        end
        chk("busy_hold", viol, 0);
        core_busy = 1'b0;
        n = 0;
        while (!fb_o[0] && n < 10) begin
          @(negedge clk);
          n++;
        end
        chk("send_after_busy", n, 1);
      end
    join
    wait_drain();

    // Reset on SEND cycle 8, then a clean "abc"
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    send_msg(1);
    n = 0;
    while (!we_o[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_start", (n < 200), 1);
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_write_enable", we_o[1], 0);
    chk("midrst_data", data_o[1], 0);
    chk("midrst_in_ready", in_ready[1], 0);
    chk("midrst_first_block", fb_o[1], 0);
    chk("midrst_last_block", lb_o[1], 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    send_msg(1);
    wait_drain();

    for (int d = 0; d < 3; d++) chk("len_err_idle", le_o[d], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Streaming message front-end for the SHA-256 core. It accepts an arbitrary-length byte message on a valid/ready stream of parametrised width and performs FIPS 180-4 padding: the 0x80 marker, zero fill, and the big-endian bit length. It then drives the core's block-load interface (`data`, `write_enable`, `first_block`, `last_block`), pacing blocks on the core's `busy` flag. It replaces hand-built padded stimulus and sits directly upstream of `top`.

## Interface
- `IN_BYTES`, 4: bytes per input beat; legal values are 1, 2 and 4. Bytes are big-endian, so the MS byte is first in the message.
- `LEN_W`, 32: width of the internal bit-length counter. Bits 63..`LEN_W` of the length field are sent as 0.
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the input beat is valid.
- `in_ready` out 1: the padder accepts the beat this cycle.
- `in_data` in 8*IN_BYTES: message bytes.
- `in_nbytes` in $clog2(IN_BYTES+1): number of valid bytes, left-justified. It must equal IN_BYTES unless `in_last`=1. The value 0 is legal only with `in_last`, which gives an empty message or tail.
- `in_last` in 1: final beat of the message.
- `core_busy` in 1: the core's `busy` output.
- `data` out 32: word to the core.
- `write_enable` out 1: `data` is valid.
- `first_block` out 1: start of a new message.
- `last_block` out 1: the current block is the final block.
- `len_err` out 1: length overflow flag (see Configuration).

## Operation
- There is a single 16x32 block buffer and a byte pointer `bp` (0..63). The FSM states are IDLE, FILL, PAD, WAIT, SEND.
- IDLE→FILL happens on the first `in_valid`. `in_ready`=1 only in IDLE and FILL.
- FILL:
  - Each accepted beat writes `in_nbytes` bytes at `bp`, advances `bp`, and adds 8*`in_nbytes` to the length.
  - When `bp` reaches 64, the block is marked "data-full" and the FSM goes to WAIT.
  - An accepted beat with `in_last` goes to PAD.
  - Beats never straddle a block, because IN_BYTES divides 64.
- PAD writes one word per cycle, starting at word `bp/4`:
  - If the 0x80 marker is not yet placed, byte `bp` gets 0x80.
  - All other bytes are filled with 0x00.
  - Words 14–15 get the 64-bit length if the marker landed at byte ≤55. That block is then final.
  - If the marker landed at byte 56–63, the block ends zero-filled and is sent non-final. A second, "length-only" block follows (words 0–13 zero, 14–15 length), which is final.
  - If the message ends exactly on a 64-byte boundary, the data-full block is sent non-final. The marker then goes to byte 0 of the next block.
- WAIT: the FSM holds until `core_busy`=0, then goes to SEND.
- SEND takes 17 cycles:
  - Cycle 0: lead cycle. `write_enable`=0; `first_block`=1 if this is block 0 of the message.
  - Cycles 1–16: `write_enable`=1, `data`=word[k-1].
  - Cycle 1 also carries `first_block`=1 for block 0, and `last_block`=1 for the final block.
- After SEND:
  - If the block was final, the FSM goes to IDLE.
  - If padding is pending, it goes to PAD.
  - Otherwise it goes to FILL with `bp`=0.
- The length counter clears on entry to IDLE.

## Timing
- Reset values: `in_ready`=0, `data`=0, `write_enable`=0, `first_block`=0, `last_block`=0, `len_err`=0. The state is IDLE, `bp`=0, length=0, and the buffer is don't-care.
- `in_ready` goes to 1 in the first cycle after reset deassertion.
- All outputs are registered. `data` is 0 whenever `write_enable`=0.
- After SEND completes, `core_busy` is ignored for 2 cycles, covering the core's busy-rise latency.
- Latency: from the `in_last` beat accepted to the first `write_enable` is (16 − `bp`/4) + 1 PAD cycles, plus the WAIT cycles, plus 1 lead cycle.
- `in_valid` without `in_ready` has no effect. Upstream must hold the beat.
- Reset asserted mid-SEND drops `write_enable` immediately (async clear) and discards the message.

## Configuration
- `SHA_PAD_LENCHK_EN`:
  - Defined: if a beat would overflow the `LEN_W`-bit length, `len_err` is set (sticky) and the beat is still consumed. `len_err` clears only on reset.
  - Undefined: `len_err` is tied to 0, the length wraps modulo 2^LEN_W, and no check logic is built.

## Test plan
- IN_BYTES=4, 14 beats of 0x30303030, `in_last` on beat 14 with `in_nbytes`=4:
  - Block 0 is words 0–13 = 0x30303030, word 14 = 0x80000000, word 15 = 0, with `first_block` set.
  - Block 1 is words 0–14 = 0, word 15 = 0x000001C0, with `last_block` set.
  - The core digest is bd03ac14…857ffc18.
- IN_BYTES=1, bytes "abc" → one block: word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018. `first_block` and `last_block` are both on SEND cycle 1.
- Empty message (single beat, `in_nbytes`=0, `in_last`) → word 0 = 0x80000000, all other words 0, single final block.
- IN_BYTES=2, 64-byte message → two blocks. The second block has word 0 = 0x80000000 and word 15 = 0x00000200.
- Hold `core_busy`=1 for 100 cycles while the block is full → no `write_enable` and `in_ready`=0 throughout. SEND starts 1 cycle after `core_busy` falls.
- Assert `reset` on SEND cycle 8, release, then send "abc" → outputs are 0 during reset. The new message's first block carries `first_block` and has a correct length of 0x18.
